audio_prgrm_ctrl: RTL

- Programming sequencer for the audio_app DSP.
- Accepts parallel coefficient/config words from a host over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each word onto the DSP's prgrm_in / prgrm_go_ serial program port.
- Monitors the DSP's err_ output, aborts on error and holds a sticky status.

---
 rtl/audio_pkg.sv | 27 ++
 rtl/audio_prgrm_fifo.sv | 66 ++++++
 rtl/audio_prgrm_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared types and constants for the audio_app programming
//               sequencer (state encoding, default word width, counter width).
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

   localparam int PRGRM_WORD_W = 16;
   localparam int FRAME_CNT_W  = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_GAP   = 3'd3,
      ST_ERR   = 3'd4
   } prgrm_state_e;

   // Counter width able to hold values 0..v-1, never narrower than one bit.
   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/audio_prgrm_fifo.sv
`default_nettype none
// ============================================================================
// Module      : audio_prgrm_fifo
// Description : Synchronous FIFO with push/pop/flush and full/empty flags
//               buffering host program words ahead of the serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_prgrm_fifo
   import audio_pkg::*;
#(
   parameter int WORD_W     = PRGRM_WORD_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [WORD_W-1:0] data_i,
   input  logic              pop_i,
   input  logic              flush_i,
   output logic [WORD_W-1:0] data_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int AW = clog2_min1(FIFO_DEPTH);

   logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [AW:0]       count_q;
   logic              w_do_push;
   logic              w_do_pop;

   assign full_o    = (count_q == (AW+1)'(FIFO_DEPTH));
   assign empty_o   = (count_q == '0);
   assign w_do_push = push_i && !full_o;
   assign w_do_pop  = pop_i && !empty_o;
   assign data_o    = mem_q[rd_ptr_q];

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (w_do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule
`default_nettype wire

// File: rtl/audio_prgrm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : audio_prgrm_ctrl
// Description : Buffers host program words and serializes them MSB first onto
//               the DSP prgrm_in/prgrm_go_ port, aborting on DSP err_.
//               Optional macro AUDIO_PRGRM_PARITY_EN appends an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_prgrm_ctrl
   import audio_pkg::*;
#(
   parameter int WORD_W     = PRGRM_WORD_W,
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYC    = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_valid,
   input  logic [WORD_W-1:0]      wr_data,
   output logic                   wr_ready,
   output logic                   prgrm_in,
   output logic                   prgrm_go_,
   input  logic                   err_,
   input  logic                   err_clr,
   output logic                   busy,
   output logic                   err_sticky,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

`ifdef AUDIO_PRGRM_PARITY_EN
   localparam int FRAME_BITS = WORD_W + 1;
`else
   localparam int FRAME_BITS = WORD_W;
`endif
   localparam int CNT_W = clog2_min1(FRAME_BITS);
   localparam int GAP_W = clog2_min1(GAP_CYC);

   prgrm_state_e           state_q, state_d;
   logic [WORD_W-1:0]      shreg_q, shreg_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
   logic                   go_n_q, go_n_d;
   logic                   pin_q, pin_d;
   logic                   sticky_q, sticky_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic                   err_n_q;
`ifdef AUDIO_PRGRM_PARITY_EN
   logic                   parity_q, parity_d;
`endif

   logic                   w_push;
   logic                   w_pop;
   logic                   w_flush;
   logic                   w_full;
   logic                   w_empty;
   logic [WORD_W-1:0]      w_head;

   assign wr_ready   = !w_full && (state_q != ST_ERR);
   assign w_push     = wr_valid && wr_ready;
   assign busy       = !w_empty || (state_q != ST_IDLE);
   assign prgrm_in   = pin_q;
   assign prgrm_go_  = go_n_q;
   assign err_sticky = sticky_q;
   assign frame_cnt  = frame_cnt_q;

   audio_prgrm_fifo #(
      .WORD_W     (WORD_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (w_push),
      .data_i  (wr_data),
      .pop_i   (w_pop),
      .flush_i (w_flush),
      .data_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      go_n_d      = go_n_q;
      pin_d       = pin_q;
      sticky_d    = sticky_q;
      frame_cnt_d = frame_cnt_q;
      w_pop       = 1'b0;
      w_flush     = 1'b0;
`ifdef AUDIO_PRGRM_PARITY_EN
      parity_d    = parity_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (!w_empty) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            // The first bit is registered here so it is on the pins for the whole first SHIFT cycle.
            w_pop     = 1'b1;
            shreg_d   = w_head;
            bit_cnt_d = CNT_W'(FRAME_BITS - 1);
            go_n_d    = 1'b0;
            pin_d     = w_head[WORD_W-1];
`ifdef AUDIO_PRGRM_PARITY_EN
            parity_d  = ^w_head;
`endif
            state_d   = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (bit_cnt_q == '0) begin
               go_n_d      = 1'b1;
               pin_d       = 1'b0;
               gap_cnt_d   = GAP_W'(GAP_CYC - 1);
               frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
               state_d     = ST_GAP;
            end else begin
               bit_cnt_d = bit_cnt_q - CNT_W'(1);
               shreg_d   = shreg_q << 1;
               pin_d     = shreg_q[WORD_W-2];
`ifdef AUDIO_PRGRM_PARITY_EN
               if (bit_cnt_q == CNT_W'(1)) pin_d = parity_q;
`endif
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == '0) state_d = ST_IDLE;
            else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
         end
         ST_ERR: begin
            w_flush = 1'b1;
            if (err_clr && err_n_q) begin
               sticky_d = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // An error from any active state overrides the normal step, including a frame's final count.
      if ((state_q != ST_ERR) && !err_n_q) begin
         state_d     = ST_ERR;
         go_n_d      = 1'b1;
         pin_d       = 1'b0;
         sticky_d    = 1'b1;
         frame_cnt_d = frame_cnt_q;
         w_flush     = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         go_n_q      <= 1'b1;
         pin_q       <= 1'b0;
         sticky_q    <= 1'b0;
         frame_cnt_q <= '0;
         err_n_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         go_n_q      <= go_n_d;
         pin_q       <= pin_d;
         sticky_q    <= sticky_d;
         frame_cnt_q <= frame_cnt_d;
         err_n_q     <= err_;
      end
   end

`ifdef AUDIO_PRGRM_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) parity_q <= 1'b0;
      else     parity_q <= parity_d;
   end
`endif

endmodule
`default_nettype wire
